fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the pipelined processor. Holds the program counter and reads 8-bit instructions from an internal instruction ROM. Presents the fetched instruction, its PC and a valid flag to the decode stage, where the opcode field drives the control unit. Accepts a same-cycle jump redirect from decode and a stall from the hazard logic, inserting a bubble on every taken jump.

## Interface
- `ADDR_W`, 6: PC / ROM address width; ROM depth is 2^ADDR_W.
- `INSTR_W`, 8: instruction width; opcode is bits [7:6].
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `stall` input 1: hold the PC and the IF/ID register for this cycle.
- `jump` input 1: from the decode-stage control unit; a taken jump in ID this cycle.
- `jump_target` input ADDR_W: from decode, `if_id_instr[ADDR_W-1:0]`; absolute target address.
- `pc` output ADDR_W: current fetch address.
- `if_id_instr` output INSTR_W: registered instruction for decode.
- `if_id_pc` output ADDR_W: address `if_id_instr` was fetched from.
- `if_id_valid` output 1: IF/ID holds a real instruction; decode gates RegWrite with it.

## Operation
- Instruction format, fixed:
  - opcode [7:6]: 00 mov, 01 sll, 11 jump, 10 reserved (treated as data, passed through).
  - mov/sll: operands in [5:0].
  - jump: target in [5:0].
- Bubble value: `if_id_instr` = 8'h00 with `if_id_valid` = 0.
  - Opcode 00 decodes jump=0, so a bubble can never redirect fetch.
- Per-edge priority: reset > jump > stall > advance.
  - **reset:** pc←0, if_id_instr←8'h00, if_id_pc←0, if_id_valid←0.
  - **jump:**
    - pc←jump_target.
    - IF/ID←bubble; the instruction fetched this cycle is discarded.
    - jump overrides a simultaneous stall.
  - **stall (no jump):** pc, if_id_instr, if_id_pc and if_id_valid all hold.
  - **advance:**
    - if_id_instr←rom[pc], if_id_pc←pc, if_id_valid←1.
    - pc←pc+1 modulo 2^ADDR_W; 63 wraps to 0 with no flag.
- ROM read is combinational on `pc`; contents are a fixed program in `instr_rom`.
- `jump` is taken from the control unit unqualified. Only a valid IF/ID word can carry opcode 11, because bubbles are 8'h00.

## Timing
- Reset values: pc=0, if_id_instr=8'h00, if_id_pc=0, if_id_valid=0.
- Fetch latency: 1 cycle. rom[pc] appears on `if_id_instr` after the edge at which pc was sampled.
- First edge after reset deasserts: if_id_instr=rom[0], if_id_pc=0, if_id_valid=1, pc=1.
- Taken jump costs exactly 1 bubble. For a jump in ID at edge N:
  - after N: pc=target, IF/ID=bubble.
  - after N+1: IF/ID=rom[target], pc=target+1.
- Stall held for k cycles freezes all outputs for k edges. Fetch resumes on the first edge with stall=0, with no lost or duplicated instruction.
- Reset asserted mid-stream, including during stall or jump, wins at that edge. The next fetch after release is from address 0.
- Back-to-back jumps cannot occur, since the slot after a jump is always a bubble.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W`, `ADDR_W`.
  - Opcode constants `OP_MOV`=2'b00, `OP_SLL`=2'b01, `OP_JMP`=2'b11.
  - `NOP_INSTR`=8'h00.
- The decode-stage control unit uses the same opcode constants.
- Sub-module `instr_rom`:
  - input `addr` [ADDR_W-1:0], output `instr` [INSTR_W-1:0].
  - combinational case-based program.
  - unlisted addresses return `NOP_INSTR`.
- `fetch_unit` contains only the PC register, the IF/ID register and the priority mux.

## Test plan
- **Reset and sequential fetch:** reset 2 cycles, then release with ROM[0..2]=8'h05,8'h4A,8'h13 → outputs are 00/0/0, then (05,pc0,v1), (4A,1,1), (13,2,1), with pc=3.
- **Wrap-around:** jump to 62 and run free → if_id_pc sequence 62, 63, 0, 1; pc goes 63→0 with no glitch.
- **Taken jump:** ROM[5]=8'hD0 (jump 16), with jump driven from its decode → cycle after 5 in ID shows a bubble (00, valid 0). Then rom[16] with if_id_pc=16, pc=17.
- **Stall:** stall 3 cycles with ROM[3] in IF/ID → if_id_instr, if_id_pc=3 and pc=4 hold for 3 edges. Next edge loads rom[4], with no duplicate of rom[3].
- **Jump with simultaneous stall:** assert both at one edge → pc=target, IF/ID=bubble, so stall is ignored.
- **Reset mid-run:** assert reset at pc=20 while jump=1 → next edge shows all reset values. Fetch restarts at rom[0].

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcode encodings and the bubble word.
package cpu_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b11;

  // Opcode 00 decodes as a non-jump, so a bubble can never redirect fetch.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

endpackage

// File: rtl/instr_rom.sv
// Fixed program ROM: combinational read, 0-cycle latency; no flow control.
// Any address not listed below returns NOP_INSTR.
module instr_rom
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] instr
);

  always_comb begin
    instr = NOP_INSTR;
    case (addr)
      6'd0:  instr = {OP_MOV, 6'h05};
      6'd1:  instr = {OP_SLL, 6'h0A};
      6'd2:  instr = {OP_MOV, 6'h13};
      6'd3:  instr = {OP_MOV, 6'h27};
      6'd4:  instr = {OP_SLL, 6'h01};
      6'd5:  instr = {OP_JMP, 6'd16};
      6'd6:  instr = {OP_JMP, 6'd0};
      6'd16: instr = {OP_MOV, 6'h09};
      6'd17: instr = {OP_SLL, 6'h12};
      // Reserved opcode 10 is carried through as plain data.
      6'd18: instr = {2'b10, 6'h1A};
      6'd19: instr = {OP_JMP, 6'd3};
      6'd62: instr = {OP_MOV, 6'h3E};
      6'd63: instr = {OP_SLL, 6'h3F};
      default: instr = NOP_INSTR;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, instruction ROM read and IF/ID register; 1-cycle fetch latency.
// Priority per edge: reset > jump (loads target, inserts a bubble) > stall (holds all) > advance.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] rom_instr;

  instr_rom u_rom (
    .addr  (pc_q),
    .instr (rom_instr)
  );

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    if (jump) begin
      // The word fetched this cycle is on the wrong path and is dropped.
      pc_d    = jump_target;
      instr_d = NOP_INSTR;
      if_pc_d = pc_q;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_q + ADDR_W'(1);
      instr_d = rom_instr;
      if_pc_d = pc_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_valid = valid_q;

endmodule
